// File: rtl/tft_bus_master.sv
// tft_bus_master: 8080-style bus initiator for the CPLD TFT controller.
// Turns a valid/ready request stream into timed CS/RS/WR/RD/DATA cycles.
module tft_bus_master #(
   parameter int DW          = 16,
   parameter int SETUP_CYC   = 2,
   parameter int STROBE_CYC  = 3,
   parameter int HOLD_CYC    = 2,
   parameter int GAP_CYC     = 2,
   parameter int CS_IDLE_MAX = 16
) (
   input  logic          clk,
   input  logic          RST,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_rs,
   input  logic          req_rd,
   input  logic [DW-1:0] req_wdata,
   input  logic          req_last,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          busy,
   output logic          CS,
   output logic          RS,
   output logic          WR,
   output logic          RD,
   output logic [DW-1:0] DATA_out,
   output logic          DATA_oe,
   input  logic [DW-1:0] DATA_in
);

   localparam int M_A  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int M_B  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int M_C  = (M_A > M_B) ? M_A : M_B;
   localparam int MAXP = (M_C > CS_IDLE_MAX) ? M_C : CS_IDLE_MAX;
   localparam int CW   = $clog2(MAXP) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_GAP
   } state_t;

   state_t        r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [CW-1:0] r_idle, w_idle;
   logic          r_rd, w_rd;
   logic          r_last, w_last;
   logic          r_cs, w_cs;
   logic          r_rs, w_rs;
   logic          r_wr, w_wr;
   logic          r_rdn, w_rdn;
   logic [DW-1:0] r_dout, w_dout;
   logic          r_oe, w_oe;
   logic          r_ready, w_ready;
   logic          r_rsp_v, w_rsp_v;
   logic [DW-1:0] r_rdata, w_rdata;
   logic          r_busy, w_busy;

   logic w_accept;
   logic w_setup_end;
   logic w_strobe_end;
   logic w_hold_end;
   logic w_gap_end;
   logic w_idle_end;

   assign w_accept     = req_valid && r_ready;
   assign w_setup_end  = (r_cnt == CW'(SETUP_CYC - 1));
   assign w_strobe_end = (r_cnt == CW'(STROBE_CYC - 1));
   assign w_hold_end   = (r_cnt == CW'(HOLD_CYC - 1));
   assign w_gap_end    = (r_cnt == CW'(GAP_CYC - 1));
   assign w_idle_end   = (CS_IDLE_MAX != 0) &&
                         (r_idle == CW'(CS_IDLE_MAX - 1));

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_idle  = r_idle;
      w_rd    = r_rd;
      w_last  = r_last;
      w_cs    = r_cs;
      w_rs    = r_rs;
      w_wr    = r_wr;
      w_rdn   = r_rdn;
      w_dout  = r_dout;
      w_oe    = r_oe;
      w_rsp_v = 1'b0;
      w_rdata = r_rdata;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state = S_SETUP;
               w_cnt   = '0;
               w_idle  = '0;
               w_rd    = req_rd;
               w_last  = req_last;
               w_cs    = 1'b0;
               w_rs    = req_rs;
               w_oe    = !req_rd;
               if (!req_rd) w_dout = req_wdata;
            end else if (!r_cs) begin
               if (w_idle_end) begin
                  w_cs    = 1'b1;
                  w_oe    = 1'b0;
                  w_idle  = '0;
                  w_cnt   = '0;
                  w_state = S_GAP;
               end else if (r_idle != {CW{1'b1}}) begin
                  w_idle = r_idle + CW'(1);
               end
            end
         end
         S_SETUP: begin
            if (w_setup_end) begin
               w_state = S_STROBE;
               w_cnt   = '0;
               if (r_rd) w_rdn = 1'b0;
               else      w_wr  = 1'b0;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_STROBE: begin
            if (w_strobe_end) begin
               w_state = S_HOLD;
               w_cnt   = '0;
               w_wr    = 1'b1;
               w_rdn   = 1'b1;
               if (r_rd) begin
                  w_rdata = DATA_in;
                  w_rsp_v = 1'b1;
               end
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_HOLD: begin
            if (w_hold_end) begin
               w_cnt  = '0;
               w_idle = '0;
               if (r_last) begin
                  w_cs    = 1'b1;
                  w_oe    = 1'b0;
                  w_state = S_GAP;
               end else begin
                  w_state = S_IDLE;
               end
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_GAP: begin
            if (w_gap_end) begin
               w_state = S_IDLE;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         default: w_state = S_IDLE;
      endcase
      // ready/busy are registered, so derive them from the next state
      w_ready = (w_state == S_IDLE);
      w_busy  = (w_state != S_IDLE) || !w_cs;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idle  <= '0;
         r_rd    <= 1'b0;
         r_last  <= 1'b0;
         r_cs    <= 1'b1;
         r_rs    <= 1'b1;
         r_wr    <= 1'b1;
         r_rdn   <= 1'b1;
         r_dout  <= '0;
         r_oe    <= 1'b0;
         r_ready <= 1'b0;
         r_rsp_v <= 1'b0;
         r_rdata <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idle  <= w_idle;
         r_rd    <= w_rd;
         r_last  <= w_last;
         r_cs    <= w_cs;
         r_rs    <= w_rs;
         r_wr    <= w_wr;
         r_rdn   <= w_rdn;
         r_dout  <= w_dout;
         r_oe    <= w_oe;
         r_ready <= w_ready;
         r_rsp_v <= w_rsp_v;
         r_rdata <= w_rdata;
         r_busy  <= w_busy;
      end
   end

   assign req_ready = r_ready;
   assign rsp_valid = r_rsp_v;
   assign rsp_rdata = r_rdata;
   assign busy      = r_busy;
   assign CS        = r_cs;
   assign RS        = r_rs;
   assign WR        = r_wr;
   assign RD        = r_rdn;
   assign DATA_out  = r_dout;
   assign DATA_oe   = r_oe;

endmodule
